// File: rtl/alu_ctrl_pipe_if.sv
// rtl/alu_ctrl_pipe_if.sv - handshake bus between the ID stage, the ALU control stage and the ALU
interface alu_ctrl_pipe_if #(
    parameter int SEL_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [5:0]       funct;
    logic [2:0]       alu_op;
    logic             out_valid;
    logic             out_ready;
    logic [SEL_W-1:0] select;
    logic             illegal;

    modport master (
        output in_valid, funct, alu_op, out_ready,
        input  in_ready, out_valid, select, illegal
    );

    modport slave (
        input  in_valid, funct, alu_op, out_ready,
        output in_ready, out_valid, select, illegal
    );
endinterface

// File: rtl/alu_ctrl_pipe.sv
// rtl/alu_ctrl_pipe.sv - registered MIPS ALU control decode with valid/ready, flush and error counter
// Optional feature macro: ALU_CTRL_EXT_EN (xor/nor/sra/sltu and alu_op=6 xori).
module alu_ctrl_pipe #(
    parameter int SEL_W = 4,
    parameter int ERR_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    alu_ctrl_pipe_if.slave        bus,
    input  logic                  flush,
    input  logic                  err_clr,
    output logic [ERR_W-1:0]      err_count
);
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [3:0] dec_sel;
    logic       dec_ill;
    logic       accept;
    logic       accept_ill;

    assign bus.in_ready  = !flush && (state_q == EMPTY || bus.out_ready);
    assign bus.out_valid = (state_q == FULL);
    assign accept        = bus.in_valid && bus.in_ready;
    assign accept_ill    = accept && dec_ill;

    always_comb begin
        dec_sel = 4'd0;
        dec_ill = 1'b0;
        case (bus.alu_op)
            3'd0: begin
                case (bus.funct)
                    6'h20, 6'h21: dec_sel = 4'd0;
                    6'h22, 6'h23: dec_sel = 4'd1;
                    6'h24:        dec_sel = 4'd2;
                    6'h25:        dec_sel = 4'd3;
                    6'h00:        dec_sel = 4'd4;
                    6'h02:        dec_sel = 4'd5;
                    6'h2A:        dec_sel = 4'd6;
`ifdef ALU_CTRL_EXT_EN
                    6'h26:        dec_sel = 4'd7;
                    6'h27:        dec_sel = 4'd8;
                    6'h03:        dec_sel = 4'd9;
                    6'h2B:        dec_sel = 4'd10;
`endif
                    default:      dec_ill = 1'b1;
                endcase
            end
            3'd1:    dec_sel = 4'd0;
            3'd2:    dec_sel = 4'd1;
            3'd3:    dec_sel = 4'd2;
            3'd4:    dec_sel = 4'd3;
            3'd5:    dec_sel = 4'd6;
`ifdef ALU_CTRL_EXT_EN
            3'd6:    dec_sel = 4'd7;
`endif
            default: dec_ill = 1'b1;
        endcase
    end

    // Flush wins over draining; an accept implies no flush because in_ready is gated by it.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = EMPTY;
        end else if (accept) begin
            state_d = FULL;
        end else if (bus.out_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Payload only moves on accept so a flushed result stays visible with out_valid low.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.select  <= '0;
            bus.illegal <= 1'b0;
        end else if (accept) begin
            bus.select  <= SEL_W'(dec_sel);
            bus.illegal <= dec_ill;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_count <= '0;
        end else if (err_clr) begin
            err_count <= accept_ill ? ERR_W'(1) : '0;
        end else if (accept_ill && err_count != {ERR_W{1'b1}}) begin
            err_count <= err_count + ERR_W'(1);
        end
    end
endmodule

// File: doc/alu_ctrl_pipe.md
# alu_ctrl_pipe

Parametrised, handshaked ALU control stage for the MIPS datapath. Decodes the main-control `alu_op` and the R-type `funct` field into an ALU `select` code, registers the result behind a valid/ready handshake, and supports flush and back-pressure. Illegal encodings are flagged per transaction and counted in a saturating error counter. The block sits between the ID stage and the ALU.

## Interface
Parameters:
- `SEL_W`, 4: width of `select`; must be ≥4.
- `ERR_W`, 8: width of `err_count`.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: upstream presents `funct` and `alu_op`.
- `in_ready` out 1: block accepts this cycle (combinational).
- `funct` in 6: R-type function field.
- `alu_op` in 3: main-control ALU operation class.
- `flush` in 1: discard the held result; block the input this cycle.
- `out_valid` out 1: `select` and `illegal` are valid.
- `out_ready` in 1: downstream consumes this cycle.
- `select` out SEL_W: ALU operation code.
- `illegal` out 1: held transaction had an illegal encoding.
- `err_clr` in 1: synchronously zeroes `err_count`.
- `err_count` out ERR_W: saturating count of accepted illegal transactions.

## Operation
- **Accept:** a transaction is accepted when `in_valid && in_ready`.
- **`in_ready`:** `!flush && (!out_valid || out_ready)`.
- **`alu_op` decode:**
  - 0 → use `funct`
  - 1 → ADD (0): lw, sw, addi
  - 2 → SUB (1): beq, bne
  - 3 → AND (2)
  - 4 → OR (3)
  - 5 → SLT (6)
  - 6, 7 → illegal
- **`funct` decode (`alu_op`=0):**
  - 0x20 add, 0x21 addu → 0
  - 0x22 sub, 0x23 subu → 1
  - 0x24 → 2
  - 0x25 → 3
  - 0x00 sll → 4
  - 0x02 srl → 5
  - 0x2A slt → 6
  - Any other `funct` is illegal.
- **Illegal transaction:** `select` = 0 and `illegal` = 1. It still passes the handshake like any other transaction.
- **Output register states:**
  - EMPTY (`out_valid`=0): accept → FULL.
  - FULL (`out_valid`=1):
    - `out_ready` with a new accept → stays FULL with new data.
    - `out_ready` without an accept → EMPTY.
    - No `out_ready` → holds `select`/`illegal` stable.
  - `flush` → EMPTY from either state. Any `in_valid` that cycle is not accepted.
- **Error counter:**
  - Increments by 1 on each accepted illegal transaction.
  - Saturates at 2^ERR_W−1.
  - `err_clr` and an illegal accept in the same cycle → 1.
  - `err_clr` alone → 0.
  - `flush` does not affect the counter.

## Timing
- Latency is 1 cycle: a transaction accepted at edge N is visible on `select`/`illegal` with `out_valid`=1 after edge N.
- Throughput is 1 per cycle while `out_ready`=1.
- Reset values: `out_valid`=0, `select`=0, `illegal`=0, `err_count`=0. `in_ready` is 1 after reset unless `flush` is high.
- `rst` overrides `flush`, `err_clr` and any handshake in the same cycle. Reset mid-stall drops the held result.
- `select`/`illegal` change only on an accept edge or on reset. They are not cleared by `flush`; only `out_valid` drops.
- `err_count` updates on the edge of the accepting cycle, so it is visible in the same cycle `out_valid` rises.

## Configuration
- Macro: `ALU_CTRL_EXT_EN`.
- **Defined:** extra R-type ops are decoded:
  - 0x26 xor → 7
  - 0x27 nor → 8
  - 0x03 sra → 9
  - 0x2B sltu → 10
  - `alu_op`=6 → XOR (7), for xori.
- **Undefined:** those `funct` values and `alu_op`=6 are illegal (`select`=0, `illegal`=1, counted).
- Handshake, latency and reset behaviour are identical either way.

## Test plan
- **Reset then stream:** `rst` 2 cycles, `out_ready`=1, `alu_op`=0, `funct` 0x20, 0x22, 0x24, 0x25, 0x00, 0x02, 0x2A on consecutive cycles → `select` 0,1,2,3,4,5,6 one cycle later each, `out_valid` continuous, `illegal`=0.
- **Back-pressure:**
  - Accept 0x22, then `out_ready`=0 for 3 cycles with `in_valid`=1 and `funct`=0x24 → `in_ready`=0, `select` holds 1.
  - Raise `out_ready` → next cycle `select`=2.
- **Flush:** FULL with `select`=3; assert `flush` with `in_valid`=1, `funct`=0x20 → next cycle `out_valid`=0, `select` still 3, nothing accepted.
- **Illegal and saturation:**
  - `ERR_W`=2; send `alu_op`=7 five times → `select`=0, `illegal`=1 each time, `err_count` 1,2,3,3,3.
  - `err_clr` together with a sixth illegal → `err_count`=1.
- **Non-R `alu_op`:** `alu_op` 1,2,3,4,5 with `funct`=0x3F → `select` 0,1,2,3,6, `illegal`=0.
- **Macro:** `funct`=0x27 → `select`=8 and `illegal`=0 with `ALU_CTRL_EXT_EN` defined; `select`=0, `illegal`=1 and `err_count`+1 without it.
